vc_arb_crossbar_sec: RTL and testbench
======================================

// Module: vc_arb_crossbar_sec
// PURPOSE
//  Parametrised N-by-N crossbar with val/rdy handshakes, per-output round-robin arbitration
//  and one-entry registered output buffers; each message carries a 1-bit security domain tag.
//  Inputs select their destination dynamically via in_dest, replacing static per-output selects.
//  Sits between masters and slaves of the on-chip interconnect; optional domain-policy filter.
// PARAMETERS
//  p_nbits      32  message payload width in bits
//  p_num_ports  3   number of inputs and of outputs (2..8)
//  c_sel_nbits  derived: max(1,$clog2(p_num_ports)), width of each in_dest field (localparam)
// PORTS
//  clk            in   1                   clock, all state updates on posedge
//  reset          in   1                   synchronous, active-high reset
//  in_msg         in   N*p_nbits           input payloads, port i at [i*p_nbits +: p_nbits]
//  in_val         in   N                   input valid, one bit per port
//  in_rdy         out  N                   input ready (combinational), one bit per port
//  in_dest        in   N*c_sel_nbits       destination output index per input
//  in_domain      in   N                   domain tag per input (0=normal, 1=secure)
//  out_msg        out  N*p_nbits           registered output payloads
//  out_val        out  N                   output valid, one bit per port
//  out_rdy        in   N                   output ready from consumer
//  out_domain     out  N                   registered domain tag of buffered message
//  out_cfg_domain in   N                   static policy: max domain each output may receive
//  sec_err        out  1                   one-cycle pulse when a message is dropped
//  sec_drop_cnt   out  8                   saturating count of dropped messages
// BEHAVIOUR
//  - Reset: out_val=0, out_msg=0, out_domain=0, all RR pointers=0, sec_err=0, sec_drop_cnt=0.
//    Reset mid-operation discards buffered messages; no output handshake completes that cycle.
//  - Transfer on input i when in_val[i]&in_rdy[i]; on output j when out_val[j]&out_rdy[j].
//  - Output j's slot is free iff !out_val[j] | out_rdy[j] (drain and fill in the same cycle allowed).
//  - Requesters of j: in_val[i] & in_dest_i==j & legal(i,j). If slot free, grant the first requester
//    found searching from ptr[j] upward, modulo N; in_rdy[i]=1 only for the grantee.
//  - On grant: ptr[j] <= (grantee+1) mod N; ptr[j] unchanged when no grant.
//  - Latency 1 cycle: message accepted at posedge t is on out_msg/out_domain with out_val=1 after t.
//    Buffered message is held stable until it drains. Full throughput: 1 msg/cycle per output.
//  - Each input targets one output, so at most one grant per input; distinct outputs proceed in parallel.
//  - in_rdy depends on in_val/in_dest/out_rdy combinationally; it must not depend on in_msg.
//  - Invalid dest (in_dest>=N): in_rdy[i]=1, message consumed and discarded, no output change;
//    counts as a drop (sec_err pulse, cnt+1) regardless of macro.
//  - sec_err registered: pulses the cycle after a drop; multiple drops in one cycle add their number
//    to sec_drop_cnt, saturating at 255 (no wrap).
// CONFIGURATION
//  - Macro VC_ARB_CROSSBAR_SEC_CHECK_EN.
//  - Defined: legal(i,j) = !(in_domain[i] & !out_cfg_domain[j]). An illegal valid input is consumed
//    (in_rdy[i]=1) the same cycle, never enters any buffer, never takes a grant or moves a pointer,
//    and counts as a drop.
//  - Undefined: legal(i,j)=1 for every valid dest; out_cfg_domain ignored; only invalid-dest drops counted.
// TESTING
//  1. After reset, in_val=001, in_msg0=0xA5, dest0=2, domain0=1 -> in_rdy0=1 same cycle; next cycle
//     out_val=100, out_msg2=0xA5, out_domain2=1.
//  2. All three inputs valid to dest 1, out_rdy=111 held -> grants rotate 0,1,2,0,1 one per cycle;
//     ptr[1] follows 1,2,0,1,2.
//  3. out_rdy1=0 with out1 full and in0 to dest 1 -> in_rdy0=0, out_msg1 stable 5 cycles; raise out_rdy1
//     -> old message drains and in0's message loads in the same cycle.
//  4. in0 to dest 2, in1 to dest 0, in2 to dest 1 simultaneously -> in_rdy=111; all outputs valid next cycle.
//  5. out_cfg_domain=000, in1 domain=1 to dest 0: macro on -> in_rdy1=1, out_val0 stays 0, sec_err pulses,
//     sec_drop_cnt=1; macro off -> delivered, out_domain0=1, cnt=0.
//  6. N=3, in2 dest=3 for 300 cycles -> in_rdy2=1 each cycle, no out_val change, sec_drop_cnt saturates at 255.

Source files
------------

// File: rtl/vc_arb_crossbar_sec.sv
// vc_arb_crossbar_sec
//   N-by-N crossbar with val/rdy handshakes on every port. Each input names its
//   destination output through in_dest; each output has a round-robin arbiter
//   and a one-entry registered buffer. Every message carries a 1-bit security
//   domain tag that travels with it to out_domain.
//
//   Optional feature, compiled in with `define VC_ARB_CROSSBAR_SEC_CHECK_EN:
//   a message tagged secure (domain=1) aimed at an output whose out_cfg_domain
//   bit is 0 is consumed and dropped instead of being delivered. Without the
//   macro only out-of-range destinations are dropped, and out_cfg_domain is
//   ignored.
//
// Ports
//   clk, reset      clock and synchronous active-high reset
//   in_msg/in_val/in_rdy/in_dest/in_domain    per-input request side
//   out_msg/out_val/out_rdy/out_domain        per-output buffered side
//   out_cfg_domain  per-output maximum domain accepted (used with the macro)
//   sec_err         registered one-cycle pulse after any drop
//   sec_drop_cnt    saturating count of dropped messages
module vc_arb_crossbar_sec #(
  parameter int unsigned p_nbits     = 32,
  parameter int unsigned p_num_ports = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [p_num_ports*p_nbits-1:0]   in_msg,
  input  logic [p_num_ports-1:0]           in_val,
  output logic [p_num_ports-1:0]           in_rdy,
  input  logic [p_num_ports*((p_num_ports > 1) ? $clog2(p_num_ports) : 1)-1:0] in_dest,
  input  logic [p_num_ports-1:0]           in_domain,
  output logic [p_num_ports*p_nbits-1:0]   out_msg,
  output logic [p_num_ports-1:0]           out_val,
  input  logic [p_num_ports-1:0]           out_rdy,
  output logic [p_num_ports-1:0]           out_domain,
  input  logic [p_num_ports-1:0]           out_cfg_domain,
  output logic                             sec_err,
  output logic [7:0]                       sec_drop_cnt
);

  localparam int unsigned c_sel_nbits = (p_num_ports > 1) ? $clog2(p_num_ports) : 1;

`ifdef VC_ARB_CROSSBAR_SEC_CHECK_EN
  localparam bit c_check_en = 1'b1;
`else
  localparam bit c_check_en = 1'b0;
  logic unused_cfg;
  assign unused_cfg = ^out_cfg_domain;
`endif

  logic [p_num_ports*p_nbits-1:0] out_msg_q,    out_msg_d;
  logic [p_num_ports-1:0]         out_val_q,    out_val_d;
  logic [p_num_ports-1:0]         out_domain_q, out_domain_d;
  logic [c_sel_nbits-1:0]         ptr_q [p_num_ports];
  logic [c_sel_nbits-1:0]         ptr_d [p_num_ports];
  logic                           sec_err_q,    sec_err_d;
  logic [7:0]                     sec_drop_cnt_q, sec_drop_cnt_d;

  logic [p_num_ports-1:0] drop;
  logic [p_num_ports-1:0] in_rdy_c;
  logic [p_num_ports-1:0] req [p_num_ports];  // req[j][i]: input i requests output j
  logic [3:0]             n_drop;
  logic [8:0]             cnt_sum;

  // Request decode and drop classification. Dropped inputs are acknowledged
  // immediately so they never stall behind a busy output.
  always_comb begin
    drop = '0;
    for (int unsigned j = 0; j < p_num_ports; j++) req[j] = '0;
    for (int unsigned i = 0; i < p_num_ports; i++) begin
      logic [c_sel_nbits-1:0] dest;
      logic                   dest_ok;
      logic                   legal;
      dest    = in_dest[i*c_sel_nbits +: c_sel_nbits];
      dest_ok = 32'(dest) < p_num_ports;
      legal   = 1'b1;
      if (dest_ok && c_check_en)
        legal = !(in_domain[i] && !out_cfg_domain[dest]);
      if (in_val[i]) begin
        if (!dest_ok || !legal) drop[i] = 1'b1;
        else                    req[dest][i] = 1'b1;
      end
    end
  end

  // Per-output round-robin grant and buffer update.
  always_comb begin
    in_rdy_c     = drop;
    out_msg_d    = out_msg_q;
    out_val_d    = out_val_q;
    out_domain_d = out_domain_q;
    for (int unsigned j = 0; j < p_num_ports; j++) ptr_d[j] = ptr_q[j];
    for (int unsigned j = 0; j < p_num_ports; j++) begin
      logic        found;
      int unsigned gidx;
      found = 1'b0;
      gidx  = 0;
      for (int unsigned k = 0; k < p_num_ports; k++) begin
        int unsigned idx;
        idx = (32'(ptr_q[j]) + k) % p_num_ports;
        if (!found && req[j][idx]) begin
          found = 1'b1;
          gidx  = idx;
        end
      end
      if (out_val_q[j] && out_rdy[j]) out_val_d[j] = 1'b0;
      if (found && (!out_val_q[j] || out_rdy[j])) begin
        in_rdy_c[gidx]                   = 1'b1;
        out_val_d[j]                     = 1'b1;
        out_msg_d[j*p_nbits +: p_nbits]  = in_msg[gidx*p_nbits +: p_nbits];
        out_domain_d[j]                  = in_domain[gidx];
        ptr_d[j]                         = c_sel_nbits'((gidx + 1) % p_num_ports);
      end
    end
  end

  // Drop accounting: several drops in one cycle add together, saturating at 255.
  always_comb begin
    n_drop = '0;
    for (int unsigned i = 0; i < p_num_ports; i++) n_drop = n_drop + 4'(drop[i]);
    cnt_sum        = {1'b0, sec_drop_cnt_q} + 9'(n_drop);
    sec_drop_cnt_d = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
    sec_err_d      = |drop;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_msg_q      <= '0;
      out_val_q      <= '0;
      out_domain_q   <= '0;
      sec_err_q      <= 1'b0;
      sec_drop_cnt_q <= '0;
      for (int unsigned j = 0; j < p_num_ports; j++) ptr_q[j] <= '0;
    end else begin
      out_msg_q      <= out_msg_d;
      out_val_q      <= out_val_d;
      out_domain_q   <= out_domain_d;
      sec_err_q      <= sec_err_d;
      sec_drop_cnt_q <= sec_drop_cnt_d;
      for (int unsigned j = 0; j < p_num_ports; j++) ptr_q[j] <= ptr_d[j];
    end
  end

  assign in_rdy       = in_rdy_c;
  assign out_msg      = out_msg_q;
  assign out_val      = out_val_q;
  assign out_domain   = out_domain_q;
  assign sec_err      = sec_err_q;
  assign sec_drop_cnt = sec_drop_cnt_q;

endmodule

// File: tb/tb_vc_arb_crossbar_sec.sv
// Testbench for vc_arb_crossbar_sec (N=3, 32-bit payload): a table of directed
// single-cycle vectors plus hand-written multi-cycle sequences.
module tb_vc_arb_crossbar_sec;

  localparam int unsigned N  = 3;
  localparam int unsigned NB = 32;

  logic            clk;
  logic            reset;
  logic [N*NB-1:0] in_msg;
  logic [N-1:0]    in_val;
  logic [N-1:0]    in_rdy;
  logic [2*N-1:0]  in_dest;
  logic [N-1:0]    in_domain;
  logic [N*NB-1:0] out_msg;
  logic [N-1:0]    out_val;
  logic [N-1:0]    out_rdy;
  logic [N-1:0]    out_domain;
  logic [N-1:0]    out_cfg_domain;
  logic            sec_err;
  logic [7:0]      sec_drop_cnt;

  vc_arb_crossbar_sec #(.p_nbits(NB), .p_num_ports(N)) dut (
    .clk(clk), .reset(reset),
    .in_msg(in_msg), .in_val(in_val), .in_rdy(in_rdy), .in_dest(in_dest),
    .in_domain(in_domain),
    .out_msg(out_msg), .out_val(out_val), .out_rdy(out_rdy),
    .out_domain(out_domain), .out_cfg_domain(out_cfg_domain),
    .sec_err(sec_err), .sec_drop_cnt(sec_drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_msg = '0; in_val = '0; in_dest = '0; in_domain = '0;
    out_rdy = '0; out_cfg_domain = '1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [2:0] val;
    logic [5:0] dest;      // {dest2, dest1, dest0}
    logic [2:0] ordy;
    logic [2:0] exp_rdy;   // combinational, before the edge
    logic [2:0] exp_oval;  // after the edge
    logic       exp_err;   // after the edge
  } vec_t;

  vec_t tbl [9];

  initial begin
    // Sequence from reset; ptrs start at 0, out_cfg_domain=111 and domain 0 throughout.
    tbl[0] = '{3'b001, 6'b00_00_10, 3'b111, 3'b001, 3'b100, 1'b0}; // in0 -> out2
    tbl[1] = '{3'b000, 6'b00_00_00, 3'b111, 3'b000, 3'b000, 1'b0}; // out2 drains
    tbl[2] = '{3'b111, 6'b01_00_10, 3'b111, 3'b111, 3'b111, 1'b0}; // permutation, all parallel
    tbl[3] = '{3'b000, 6'b00_00_00, 3'b000, 3'b000, 3'b111, 1'b0}; // hold
    tbl[4] = '{3'b011, 6'b00_00_00, 3'b000, 3'b000, 3'b111, 1'b0}; // out0 full, stalled
    tbl[5] = '{3'b011, 6'b00_00_00, 3'b001, 3'b001, 3'b111, 1'b0}; // ptr0=2 -> grant in0
    tbl[6] = '{3'b011, 6'b00_00_00, 3'b111, 3'b010, 3'b001, 1'b0}; // ptr0=1 -> grant in1
    tbl[7] = '{3'b100, 6'b11_00_00, 3'b111, 3'b100, 3'b000, 1'b1}; // invalid dest dropped
    tbl[8] = '{3'b000, 6'b00_00_00, 3'b111, 3'b000, 3'b000, 1'b0};

    reset = 1'b1;
    idle_inputs();

    // Reset state
    step(); step();
    reset = 1'b0;
    chk("rst_out_val", 32'(out_val), 0);
    chk("rst_out_msg", out_msg[31:0] | out_msg[63:32] | out_msg[95:64], 0);
    chk("rst_out_domain", 32'(out_domain), 0);
    chk("rst_sec_err", 32'(sec_err), 0);
    chk("rst_drop_cnt", 32'(sec_drop_cnt), 0);

    // Single secure message to output 2
    in_val = 3'b001; in_msg[31:0] = 32'hA5; in_dest = 6'b00_00_10; in_domain = 3'b001;
    #1 chk("t1_in_rdy", 32'(in_rdy), 32'b001);
    step();
    in_val = '0;
    chk("t1_out_val", 32'(out_val), 32'b100);
    chk("t1_out_msg2", out_msg[95:64], 32'hA5);
    chk("t1_out_domain", 32'(out_domain), 32'b100);

    // Table vectors
    do_reset();
    for (int v = 0; v < 9; v++) begin
      in_val = tbl[v].val; in_dest = tbl[v].dest; out_rdy = tbl[v].ordy;
      for (int i = 0; i < 3; i++) in_msg[i*NB +: NB] = 32'(v * 16 + i);
      #1 chk($sformatf("vec%0d_in_rdy", v), 32'(in_rdy), 32'(tbl[v].exp_rdy));
      step();
      chk($sformatf("vec%0d_out_val", v), 32'(out_val), 32'(tbl[v].exp_oval));
      chk($sformatf("vec%0d_sec_err", v), 32'(sec_err), 32'(tbl[v].exp_err));
    end

    // Round-robin rotation on output 1
    do_reset();
    in_val = 3'b111; in_dest = 6'b01_01_01; out_rdy = 3'b111;
    for (int i = 0; i < 3; i++) in_msg[i*NB +: NB] = 32'h20 + 32'(i);
    for (int k = 0; k < 5; k++) begin
      #1 chk($sformatf("rr%0d_in_rdy", k), 32'(in_rdy), 32'(1 << (k % 3)));
      step();
      chk($sformatf("rr%0d_out_msg1", k), out_msg[63:32], 32'h20 + 32'(k % 3));
    end

    // Backpressure on output 1, then drain and refill in one cycle
    do_reset();
    in_val = 3'b001; in_dest = 6'b00_00_01; in_msg[31:0] = 32'h31;
    step();
    in_msg[31:0] = 32'h32;
    for (int k = 0; k < 5; k++) begin
      #1 chk($sformatf("bp%0d_in_rdy0", k), 32'(in_rdy[0]), 0);
      step();
      chk($sformatf("bp%0d_out_msg1", k), out_msg[63:32], 32'h31);
    end
    out_rdy = 3'b010;
    #1 chk("bp_release_in_rdy0", 32'(in_rdy[0]), 1);
    step();
    in_val = '0; out_rdy = '0;
    chk("bp_release_out_val1", 32'(out_val[1]), 1);
    chk("bp_release_out_msg1", out_msg[63:32], 32'h32);

    // Secure message to an output configured for normal domain only
    do_reset();
    out_cfg_domain = 3'b000; out_rdy = 3'b111;
    in_val = 3'b010; in_dest = 6'b00_00_00; in_domain = 3'b010; in_msg[63:32] = 32'h55;
    #1 chk("sec_in_rdy1", 32'(in_rdy[1]), 1);
    step();
    in_val = '0;
`ifdef VC_ARB_CROSSBAR_SEC_CHECK_EN
    chk("sec_out_val0", 32'(out_val[0]), 0);
    chk("sec_err_pulse", 32'(sec_err), 1);
    chk("sec_drop_cnt", 32'(sec_drop_cnt), 1);
`else
    chk("sec_out_val0", 32'(out_val[0]), 1);
    chk("sec_out_domain0", 32'(out_domain[0]), 1);
    chk("sec_out_msg0", out_msg[31:0], 32'h55);
    chk("sec_err_pulse", 32'(sec_err), 0);
    chk("sec_drop_cnt", 32'(sec_drop_cnt), 0);
`endif
    step();
    chk("sec_err_one_cycle", 32'(sec_err), 0);

    // Invalid destination flood: counter saturates at 255 rather than wrapping
    do_reset();
    in_val = 3'b100; in_dest = 6'b11_00_00; out_rdy = 3'b111;
    for (int k = 0; k < 300; k++) begin
      #1 chk("flood_in_rdy2", 32'(in_rdy[2]), 1);
      step();
      chk("flood_out_val", 32'(out_val), 0);
      if (k == 199) chk("flood_cnt_200", 32'(sec_drop_cnt), 200);
    end
    in_val = '0;
    step();
    chk("flood_cnt_sat", 32'(sec_drop_cnt), 255);

    // Reset while a message is buffered discards it
    do_reset();
    in_val = 3'b001; in_dest = 6'b00_00_00; in_msg[31:0] = 32'h77;
    step();
    in_val = '0;
    chk("mid_rst_loaded", 32'(out_val[0]), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_out_val", 32'(out_val), 0);
    chk("mid_rst_out_msg0", out_msg[31:0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
